// File: rtl/cla_pipe_addsub_if.sv
// Valid/ready operand and result bundle for the pipelined CLA add/sub.
// master drives operands and result-ready; slave is the adder side.
interface cla_pipe_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_pipe_addsub.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers bit and nibble P/G; stage 2 resolves carries and the sum.
module cla_pipe_addsub #(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    cla_pipe_addsub_if.slave bus
);
    localparam int NG = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NG-1:0]    gp;
        logic [NG-1:0]    gg;
        logic             c0;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } s2_t;

    // Flattened two-level AND-OR lookahead across four P/G slots.
    function automatic logic [4:1] cla4(
        input logic [3:0] p,
        input logic [3:0] g,
        input logic       c
    );
        logic [4:1] co;
        co[1] = g[0] | (p[0] & c);
        co[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        co[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c);
        co[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c);
        return co;
    endfunction

    s1_t              s1_new;
    s1_t              s1_d;
    s1_t              s1_q;
    logic             s1_valid_d;
    logic             s1_valid_q;
    s2_t              s2_new;
    s2_t              s2_d;
    s2_t              s2_q;
    logic             out_valid_d;
    logic             out_valid_q;

    logic [WIDTH-1:0] b_eff;
    logic [3:0]       pk;
    logic [3:0]       gk;
    logic             s2_ready;
    logic             in_ready;
    logic             in_fire;
    logic             s1_adv;

    logic [3:0]       gp4;
    logic [3:0]       gg4;
    logic [4:0]       gc;
    logic [WIDTH-1:0] cb;
    logic [4:1]       nib;
    logic [NG-1:0]    nib_co;
    logic             unused_co;

    assign s2_ready = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_ready;
    assign in_fire  = bus.in_valid && in_ready;
    assign s1_adv   = s1_valid_q && s2_ready;

    always_comb begin : stage1_terms
        b_eff     = bus.b ^ {WIDTH{bus.sub}};
        s1_new    = '0;
        s1_new.p  = bus.a ^ b_eff;
        s1_new.g  = bus.a & b_eff;
        s1_new.c0 = bus.cin ^ bus.sub;
        pk        = '0;
        gk        = '0;
        for (int k = 0; k < NG; k++) begin
            pk = s1_new.p[4*k +: 4];
            gk = s1_new.g[4*k +: 4];
            s1_new.gp[k] = &pk;
            s1_new.gg[k] = gk[3] | (pk[3] & gk[2])
                         | (pk[3] & pk[2] & gk[1])
                         | (pk[3] & pk[2] & pk[1] & gk[0]);
        end
    end

    always_comb begin : stage2_carries
        gp4 = '0;
        gg4 = '0;
        // Slots above NG stay P=G=0, so their carries never feed a bit.
        gp4[NG-1:0] = s1_q.gp;
        gg4[NG-1:0] = s1_q.gg;
        gc     = {cla4(gp4, gg4, s1_q.c0), s1_q.c0};
        cb     = '0;
        nib    = '0;
        nib_co = '0;
        for (int k = 0; k < NG; k++) begin
            nib = cla4(s1_q.p[4*k +: 4], s1_q.g[4*k +: 4], gc[k]);
            cb[4*k]         = gc[k];
            cb[4*k+1 +: 3]  = nib[3:1];
            nib_co[k]       = nib[4];
        end
        s2_new.sum  = s1_q.p ^ cb;
        s2_new.cout = gc[NG];
        s2_new.ovf  = cb[WIDTH-1] ^ gc[NG];
        unused_co   = ^{gc, nib_co};
    end

    always_comb begin : next_state
        s1_d        = in_fire ? s1_new : s1_q;
        s1_valid_d  = in_fire ? 1'b1 : (s2_ready ? 1'b0 : s1_valid_q);
        s2_d        = s1_adv ? s2_new : s2_q;
        out_valid_d = s2_ready ? s1_valid_q : out_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = s2_q.sum;
    assign bus.cout      = s2_q.cout;
    assign bus.ovf       = s2_q.ovf;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub at WIDTH=16 and WIDTH=4.
// Expected {ovf,cout,sum} are queued on input transfer, popped on output.
module tb_cla_pipe_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   rand_rdy = 1'b0;
    bit   force_rdy = 1'b1;

    logic [17:0] q16[$];
    logic [17:0] q4[$];
    bit          hold16 = 1'b0;
    bit          hold4 = 1'b0;
    logic [17:0] last16;
    logic [17:0] last4;

    cla_pipe_addsub_if #(.WIDTH(16)) if16 ();
    cla_pipe_addsub_if #(.WIDTH(4))  if4 ();

    cla_pipe_addsub #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    cla_pipe_addsub #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] model(int w, int a, int b,
                                          bit s, bit c);
        int t, sa, sb, st, m, h;
        logic [17:0] r;
        m  = (1 << w) - 1;
        h  = 1 << (w - 1);
        t  = s ? a - b - int'(c) : a + b + int'(c);
        sa = (a >= h) ? a - (1 << w) : a;
        sb = (b >= h) ? b - (1 << w) : b;
        st = s ? sa - sb - int'(c) : sa + sb + int'(c);
        r        = '0;
        r[15:0]  = 16'(t & m);
        r[16]    = s ? (t >= 0) : (t > m);
        r[17]    = (st >= h) || (st < -h);
        return r;
    endfunction

    task automatic send16(input logic [15:0] a, input logic [15:0] b,
                          input bit s, input bit c,
                          input logic [17:0] exp);
        int n = 0;
        if16.in_valid = 1'b1;
        if16.a = a;
        if16.b = b;
        if16.sub = s;
        if16.cin = c;
        @(negedge clk);
        while (!if16.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!if16.in_ready) chk("accept16_timeout", 0, 1);
        else q16.push_back(exp);
        @(posedge clk);
        #1;
        if16.in_valid = 1'b0;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b,
                         input bit s, input bit c,
                         input logic [17:0] exp);
        int n = 0;
        if4.in_valid = 1'b1;
        if4.a = a;
        if4.b = b;
        if4.sub = s;
        if4.cin = c;
        @(negedge clk);
        while (!if4.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!if4.in_ready) chk("accept4_timeout", 0, 1);
        else q4.push_back(exp);
        @(posedge clk);
        #1;
        if4.in_valid = 1'b0;
    endtask

    task automatic drain16();
        int n = 0;
        while (q16.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain16", q16.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain4();
        int n = 0;
        while (q4.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain4", q4.size(), 0);
    endtask

    always @(posedge clk) begin
        #1;
        if16.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
        if4.out_ready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        logic [17:0] e;
        logic [17:0] o;
        o = {if16.ovf, if16.cout, if16.sum};
        if (rst) begin
            q16.delete();
            hold16 = 1'b0;
        end else begin
            if (hold16) chk("hold16", {if16.out_valid, o}, {1'b1, last16});
            hold16 = 1'b0;
            if (if16.out_valid && if16.out_ready) begin
                if (q16.size() == 0) chk("spurious16", 1, 0);
                else begin
                    e = q16.pop_front();
                    chk("result16", o, e);
                end
            end else if (if16.out_valid) begin
                hold16 = 1'b1;
                last16 = o;
            end
        end
    end

    always @(negedge clk) begin
        logic [17:0] e;
        logic [17:0] o;
        o = {if4.ovf, if4.cout, 12'h000, if4.sum};
        if (rst) begin
            q4.delete();
            hold4 = 1'b0;
        end else begin
            if (hold4) chk("hold4", {if4.out_valid, o}, {1'b1, last4});
            hold4 = 1'b0;
            if (if4.out_valid && if4.out_ready) begin
                if (q4.size() == 0) chk("spurious4", 1, 0);
                else begin
                    e = q4.pop_front();
                    chk("result4", o, e);
                end
            end else if (if4.out_valid) begin
                hold4 = 1'b1;
                last4 = o;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        bit          rs;
        bit          rc;
        if16.in_valid = 1'b0;
        if16.a = '0;
        if16.b = '0;
        if16.sub = 1'b0;
        if16.cin = 1'b0;
        if16.out_ready = 1'b1;
        if4.in_valid = 1'b0;
        if4.a = '0;
        if4.b = '0;
        if4.sub = 1'b0;
        if4.cin = 1'b0;
        if4.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_state16", {if16.in_ready, if16.out_valid, if16.ovf,
            if16.cout, if16.sum}, {1'b1, 1'b0, 18'h0});
        chk("rst_state4", {if4.in_ready, if4.out_valid, if4.ovf,
            if4.cout, if4.sum}, {1'b1, 1'b0, 6'h0});
        @(posedge clk);
        #1;

        send16(16'h7FFF, 16'h0001, 0, 0, {1'b1, 1'b0, 16'h8000});
        @(negedge clk);
        chk("latency_c1", if16.out_valid, 0);
        @(negedge clk);
        chk("latency_c2", if16.out_valid, 1);
        @(posedge clk);
        #1;
        send16(16'h0000, 16'h0001, 1, 0, {1'b0, 1'b0, 16'hFFFF});
        send16(16'h8000, 16'h0001, 1, 0, {1'b1, 1'b1, 16'h7FFF});
        send16(16'hFFFF, 16'h0000, 0, 1, {1'b0, 1'b1, 16'h0000});
        send16(16'h1000, 16'h0FFF, 1, 1, {1'b0, 1'b1, 16'h0000});
        drain16();

        fork
            begin
                for (int i = 0; i < 6; i++)
                    send16(16'(i), 16'h0100, 0, 0, 18'(16'h0100 + i));
            end
            begin
                repeat (3) @(negedge clk);
                force_rdy = 1'b0;
                repeat (3) @(negedge clk);
                chk("stall_in_ready", if16.in_ready, 0);
                force_rdy = 1'b1;
            end
        join
        drain16();

        @(negedge clk);
        force_rdy = 1'b0;
        @(posedge clk);
        #1;
        send16(16'h0001, 16'h0001, 0, 0, 18'h2);
        send16(16'h0002, 16'h0002, 0, 0, 18'h4);
        @(negedge clk);
        chk("stall_full", {if16.out_valid, if16.in_ready}, 2'b10);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midstall_rst", {if16.out_valid, if16.in_ready, if16.sum},
            {1'b0, 1'b1, 16'h0000});
        force_rdy = 1'b1;
        @(posedge clk);
        #1;
        send16(16'h0003, 16'h0004, 0, 0, 18'h7);
        drain16();

        rand_rdy = 1'b1;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rs = 1'($urandom_range(0, 1));
                    rc = 1'($urandom_range(0, 1));
                    send16(ra, rb, rs, rc,
                           model(16, int'(ra), int'(rb), rs, rc));
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                logic [3:0] xa;
                logic [3:0] xb;
                bit         xs;
                bit         xc;
                for (int j = 0; j < 10000; j++) begin
                    xa = 4'($urandom);
                    xb = 4'($urandom);
                    xs = 1'($urandom_range(0, 1));
                    xc = 1'($urandom_range(0, 1));
                    send4(xa, xb, xs, xc,
                          model(4, int'(xa), int'(xb), xs, xc));
                    if ($urandom_range(0, 7) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
        join
        rand_rdy = 1'b0;
        drain16();
        drain4();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output.
- Generates its own bit propagate/generate terms and 4-bit group P/G, resolves group carries with a 4-bit lookahead level, then resolves the carries inside each nibble.
- Sits in the datapath wherever a registered add/sub with backpressure is needed, e.g. ALU back end or address generator.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4, range 4..16. One lookahead level spans at most 4 groups.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0: A+B+cin; 1: A−B−cin, with cin acting as borrow-in
- cin  input  1  carry-in (add) or borrow-in (sub)
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB; in sub mode 1 means no borrow
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Operand conditioning:
  - Effective b is b XOR {WIDTH{sub}}.
  - Effective carry-in c0 is cin XOR sub.
- Stage 1, registered on input handshake:
  - Bit terms: p = a ^ b_eff, g = a & b_eff.
  - Per nibble k, group propagate Pk = &p[4k+3:4k].
  - Group generate Gk = g3 | p3g2 | p3p2g1 | p3p2p1g0, with indices relative to the nibble.
  - Registers hold p, g, Pk, Gk, c0 and s1_valid.
- Stage 2, registered toward output:
  - Group carries: C[k+1] = Gk | Pk·C[k], flattened into two-level AND-OR form as in a 4-bit lookahead. C[0] = c0.
  - Bit carries inside each nibble are computed the same way from the nibble's p/g and C[k].
  - sum = p ^ carries.
  - cout = carry out of bit WIDTH−1.
  - ovf = carry into bit WIDTH−1 XOR cout.
- Latency:
  - Result appears on out_valid exactly 2 cycles after the accepting in_valid&in_ready edge, when there is no backpressure.
  - Throughput is 1 result per cycle.
- Handshake:
  - Input transfer happens when in_valid & in_ready. Output transfer happens when out_valid & out_ready.
  - s2_ready = !out_valid | out_ready.
  - in_ready = !s1_valid | s2_ready. in_ready is combinational and depends on out_ready; no combinational path exists from in_valid to in_ready.
  - A stage holds its data unchanged while valid and not advancing.
  - out_valid is never deasserted before the output transfer completes.
  - sum, cout and ovf are stable while out_valid=1 and out_ready=0.
  - Simultaneous accept and drain in the same cycle: both stages advance, with no bubble and no loss.
  - Inputs are ignored while in_ready=0. a, b, sub and cin are sampled only on the transfer edge.
- Reset:
  - rst=1 at a clock edge clears s1_valid and out_valid to 0. sum, cout and ovf reset to 0.
  - In-flight operations are discarded, including mid-stall.
  - in_ready is 1 in the cycle after reset.
- Width rules:
  - WIDTH=4 degenerates to a single group, with C[1] equal to cout.
  - Unused group-carry slots are tied off and must not affect outputs.
- Ordering: results leave in acceptance order; no reordering or duplication.

Test Plan:
- Add overflow: a=0x7FFF, b=0x0001, sub=0, cin=0 -> 2 cycles later sum=0x8000, cout=0, ovf=1.
- Subtract underflow: a=0x0000, b=0x0001, sub=1, cin=0 -> sum=0xFFFF, cout=0 (borrow), ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Full carry ripple through all groups: a=0xFFFF, b=0x0000, cin=1, sub=0 -> sum=0x0000, cout=1, ovf=0. Subtract with borrow: a=0x1000, b=0x0FFF, sub=1, cin=1 -> sum=0x0000, cout=1.
- Backpressure: stream 6 back-to-back ops (a=i, b=0x0100) with out_ready held 0 for cycles 3–5.
  - in_ready drops after 2 accepted while stalled, and sum stays stable while stalled.
  - All 6 results emerge in order as 0x0100..0x0105, with no drops.
- Reset mid-stall: 2 ops in flight with out_ready=0, then assert rst for 1 cycle.
  - Next cycle out_valid=0, sum=0, in_ready=1.
  - A new op a=3, b=4 then yields sum=7 after 2 cycles.
- Random: 10k random a/b/sub/cin with random out_ready, checked against a behavioural model A±B±c for sum, cout and ovf, for WIDTH=16 and WIDTH=4.
